execute_mdu_stage: RTL and testbench

- Execute stage directly downstream of DecodeModule.
- Registers the decode outputs: operands, store data, destination and the 14-bit control bundle. It produces the ALU result for the memory stage.
- Owns the HI/LO registers and an iterative 32-cycle multiply/divide unit (MDU).
- Raises a stall interlock when an instruction needs HI/LO before the MDU has finished.

---
 rtl/execute_mdu_stage_pkg.sv | 44 ++++
 rtl/execute_mdu_stage_mdu_iterative.sv | 112 +++++++++++
 rtl/execute_mdu_stage.sv | 111 +++++++++++
 tb/tb_execute_mdu_stage.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/execute_mdu_stage_pkg.sv
// Shared definitions for the execute stage: funct codes, MDU encodings and bundle layout.
package execute_mdu_stage_pkg;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_SLTU  = 6'h2B;

    localparam int FUNC_MSB = 13;
    localparam int FUNC_LSB = 8;
    localparam int CTRL_MSB = 7;

    typedef enum logic [1:0] {MDU_IDLE, MDU_RUN, MDU_FIX} mdu_state_t;

    // Low two funct bits of the MDU ops select the operation directly.
    typedef enum logic [1:0] {MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU} mdu_op_t;

    function automatic logic is_mdu_fn(input logic [5:0] fn);
        return (fn == FN_MULT) || (fn == FN_MULTU) || (fn == FN_DIV) || (fn == FN_DIVU);
    endfunction

    function automatic logic is_hilo_fn(input logic [5:0] fn);
        return is_mdu_fn(fn) || (fn == FN_MFHI) || (fn == FN_MFLO) ||
               (fn == FN_MTHI) || (fn == FN_MTLO);
    endfunction

endpackage

// File: rtl/execute_mdu_stage_mdu_iterative.sv
// Iterative W-cycle multiply/divide unit holding the architectural HI/LO registers.
module mdu_iterative
    import execute_mdu_stage_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  mdu_op_t      op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         wr_hi,
    input  logic         wr_lo,
    input  logic [W-1:0] wr_data,
    output logic         busy,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo
);

    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    mdu_state_t     state, state_next;
    logic [CW-1:0]  count;
    logic [W-1:0]   acc_hi, acc_lo, operand;
    logic           is_div, neg_q, neg_r, div_zero;
    logic           signed_op;
    logic [W-1:0]   mag_a, mag_b;
    logic [W:0]     mul_sum, div_shift, div_trial;
    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   quot_fix, rem_fix;

    assign signed_op = (op == MDU_MULT) || (op == MDU_DIV);
    assign mag_a     = (signed_op && a[W-1]) ? -a : a;
    assign mag_b     = (signed_op && b[W-1]) ? -b : b;
    assign busy      = (state != MDU_IDLE);

    // One shift-add multiply step, or one restoring shift-subtract divide step.
    assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);
    assign div_shift = {acc_hi, acc_lo[W-1]};
    assign div_trial = div_shift - {1'b0, operand};

    assign prod_fix  = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    assign quot_fix  = div_zero ? '1 : (neg_q ? -acc_lo : acc_lo);
    assign rem_fix   = neg_r ? -acc_hi : acc_hi;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= MDU_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            MDU_IDLE: if (start) state_next = MDU_RUN;
            MDU_RUN:  if (count == LAST) state_next = MDU_FIX;
            MDU_FIX:  state_next = MDU_IDLE;
            default:  state_next = MDU_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count    <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            operand  <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
        end else if (state == MDU_IDLE && start) begin
            count    <= '0;
            acc_hi   <= '0;
            acc_lo   <= mag_a;
            operand  <= mag_b;
            is_div   <= (op == MDU_DIV) || (op == MDU_DIVU);
            neg_q    <= signed_op && (a[W-1] ^ b[W-1]);
            neg_r    <= signed_op && a[W-1];
            div_zero <= (b == '0);
        end else if (state == MDU_RUN) begin
            count <= count + 1'b1;
            if (is_div) begin
                acc_hi <= div_trial[W] ? div_shift[W-1:0] : div_trial[W-1:0];
                acc_lo <= {acc_lo[W-2:0], ~div_trial[W]};
            end else begin
                acc_hi <= mul_sum[W:1];
                acc_lo <= {mul_sum[0], acc_lo[W-1:1]};
            end
        end
    end

    // Architectural HI/LO: the MDU result and MTHI/MTLO never land in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi <= '0;
            lo <= '0;
        end else if (state == MDU_FIX) begin
            if (is_div) begin
                hi <= rem_fix;
                lo <= quot_fix;
            end else begin
                {hi, lo} <= prod_fix;
            end
        end else begin
            if (wr_hi) hi <= wr_data;
            if (wr_lo) lo <= wr_data;
        end
    end

endmodule

// File: rtl/execute_mdu_stage.sv
// Execute stage: captures decode outputs, evaluates the ALU or HI/LO moves, and interlocks on the MDU.
module execute_mdu_stage
    import execute_mdu_stage_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [13:0]  bundle_in,
    input  logic [W-1:0] operand_a_in,
    input  logic [W-1:0] operand_b_in,
    input  logic [W-1:0] reg_read2_in,
    input  logic [4:0]   reg_write_dest_in,
    output logic [7:0]   bundle_out,
    output logic [W-1:0] alu_result_out,
    output logic [W-1:0] store_data_out,
    output logic [4:0]   reg_write_dest_out,
    output logic         stall_out,
    output logic         mdu_busy_out
);

    localparam int SHW = $clog2(W);

    logic [13:0]  bundle_p0;
    logic [W-1:0] a_p0, b_p0, store_p0;
    logic [4:0]   dest_p0;
    logic [5:0]   func;
    logic         mdu_op, stall, busy, start, wr_hi, wr_lo;
    mdu_op_t      op_sel;
    logic [W-1:0] hi, lo;

    function automatic logic [W-1:0] alu_eval(input logic [5:0] fn,
                                              input logic [W-1:0] a,
                                              input logic [W-1:0] b);
        logic signed [W-1:0] sa, sb;
        logic [SHW-1:0]      sh;
        sa = a;
        sb = b;
        sh = a[SHW-1:0];
        case (fn)
            FN_SLL:          alu_eval = b << sh;
            FN_SRL:          alu_eval = b >> sh;
            FN_SRA:          alu_eval = W'(sb >>> sh);
            FN_ADD, FN_ADDU: alu_eval = a + b;
            FN_SUB, FN_SUBU: alu_eval = a - b;
            FN_AND:          alu_eval = a & b;
            FN_OR:           alu_eval = a | b;
            FN_XOR:          alu_eval = a ^ b;
            FN_NOR:          alu_eval = ~(a | b);
            FN_SLT:          alu_eval = W'(sa < sb);
            FN_SLTU:         alu_eval = W'(a < b);
            default:         alu_eval = '0;
        endcase
    endfunction

    // Stage p0: decode outputs captured unless the interlock holds them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bundle_p0 <= '0;
            a_p0      <= '0;
            b_p0      <= '0;
            store_p0  <= '0;
            dest_p0   <= '0;
        end else if (!stall) begin
            bundle_p0 <= bundle_in;
            a_p0      <= operand_a_in;
            b_p0      <= operand_b_in;
            store_p0  <= reg_read2_in;
            dest_p0   <= reg_write_dest_in;
        end
    end

    assign func   = bundle_p0[FUNC_MSB:FUNC_LSB];
    assign mdu_op = is_mdu_fn(func);
    assign stall  = busy && is_hilo_fn(func);
    assign start  = mdu_op && !stall;
    assign wr_hi  = !stall && (func == FN_MTHI);
    assign wr_lo  = !stall && (func == FN_MTLO);
    assign op_sel = mdu_op_t'(func[1:0]);

    mdu_iterative #(.W(W)) u_mdu (
        .clk     (clk),
        .rst     (reset),
        .start   (start),
        .op      (op_sel),
        .a       (a_p0),
        .b       (b_p0),
        .wr_hi   (wr_hi),
        .wr_lo   (wr_lo),
        .wr_data (a_p0),
        .busy    (busy),
        .hi      (hi),
        .lo      (lo)
    );

    always_comb begin
        case (func)
            FN_MFHI: alu_result_out = hi;
            FN_MFLO: alu_result_out = lo;
            default: alu_result_out = alu_eval(func, a_p0, b_p0);
        endcase
    end

    // A stalled instruction and the MDU op itself send a bubble downstream.
    assign bundle_out         = (stall || mdu_op) ? 8'h00 : bundle_p0[CTRL_MSB:0];
    assign store_data_out     = store_p0;
    assign reg_write_dest_out = dest_p0;
    assign stall_out          = stall;
    assign mdu_busy_out       = busy;

endmodule

// File: tb/tb_execute_mdu_stage.sv
// Randomized bench for execute_mdu_stage with a cycle-level behavioural reference model.
module tb_execute_mdu_stage;
    import execute_mdu_stage_pkg::*;

    localparam int W = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [13:0] bundle_in = '0;
    logic [31:0] operand_a_in = '0, operand_b_in = '0, reg_read2_in = '0;
    logic [4:0]  reg_write_dest_in = '0;
    logic [7:0]  bundle_out;
    logic [31:0] alu_result_out, store_data_out;
    logic [4:0]  reg_write_dest_out;
    logic        stall_out, mdu_busy_out;

    int n_checks = 0;
    int n_fail   = 0;
    bit run_cmp  = 1'b0;

    always #5 clk = ~clk;

    execute_mdu_stage #(.W(W)) dut (
        .clk                (clk),
        .reset              (reset),
        .bundle_in          (bundle_in),
        .operand_a_in       (operand_a_in),
        .operand_b_in       (operand_b_in),
        .reg_read2_in       (reg_read2_in),
        .reg_write_dest_in  (reg_write_dest_in),
        .bundle_out         (bundle_out),
        .alu_result_out     (alu_result_out),
        .store_data_out     (store_data_out),
        .reg_write_dest_out (reg_write_dest_out),
        .stall_out          (stall_out),
        .mdu_busy_out       (mdu_busy_out)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit t_mdu(input logic [5:0] f);
        return f == 6'h18 || f == 6'h19 || f == 6'h1A || f == 6'h1B;
    endfunction

    function automatic bit t_hilo(input logic [5:0] f);
        return t_mdu(f) || (f >= 6'h10 && f <= 6'h13);
    endfunction

    function automatic logic [31:0] alu_ref(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        case (f)
            6'h00: return b << a[4:0];
            6'h02: return b >> a[4:0];
            6'h03: return 32'($signed(b) >>> a[4:0]);
            6'h20, 6'h21: return a + b;
            6'h22, 6'h23: return a - b;
            6'h24: return a & b;
            6'h25: return a | b;
            6'h26: return a ^ b;
            6'h27: return ~(a | b);
            6'h2A: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            6'h2B: return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // Returns {HI, LO}.
    function automatic logic [63:0] mdu_ref(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        longint unsigned ua, ub, uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        if (f == FN_MULT) return 64'(sa * sb);
        if (f == FN_MULTU) return ua * ub;
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (f == FN_DIV) begin
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
        end
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
    endfunction

    logic [5:0]  c_fn;
    logic [7:0]  c_ctl;
    logic [31:0] c_a, c_b, c_st, m_hi, m_lo;
    logic [4:0]  c_rd;
    logic [63:0] p_res;
    int          busy_left;

    function automatic bit m_stall();
        return busy_left != 0 && t_hilo(c_fn);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            c_fn <= '0; c_ctl <= '0; c_a <= '0; c_b <= '0; c_st <= '0; c_rd <= '0;
            m_hi <= '0; m_lo <= '0; p_res <= '0; busy_left <= 0;
        end else begin
            if (busy_left > 0) begin
                busy_left <= busy_left - 1;
                if (busy_left == 1) {m_hi, m_lo} <= p_res;
            end else if (t_mdu(c_fn)) begin
                busy_left <= W + 1;
                p_res     <= mdu_ref(c_fn, c_a, c_b);
            end else if (c_fn == FN_MTHI) begin
                m_hi <= c_a;
            end else if (c_fn == FN_MTLO) begin
                m_lo <= c_a;
            end
            if (!m_stall()) begin
                c_fn <= bundle_in[13:8]; c_ctl <= bundle_in[7:0];
                c_a <= operand_a_in; c_b <= operand_b_in;
                c_st <= reg_read2_in; c_rd <= reg_write_dest_in;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && run_cmp) begin
            check("busy", 32'(mdu_busy_out), 32'(busy_left != 0));
            check("stall", 32'(stall_out), 32'(m_stall()));
            check("bundle", 32'(bundle_out), (m_stall() || t_mdu(c_fn)) ? 32'd0 : 32'(c_ctl));
            check("store", store_data_out, c_st);
            check("dest", 32'(reg_write_dest_out), 32'(c_rd));
            if (!t_mdu(c_fn) && c_fn != FN_MTHI && c_fn != FN_MTLO)
                check("result", alu_result_out,
                      c_fn == FN_MFHI ? m_hi : (c_fn == FN_MFLO ? m_lo : alu_ref(c_fn, c_a, c_b)));
        end
    end

    // ---------------- stimulus ----------------
    // Called at a negedge; returns at the negedge after the instruction is captured.
    task automatic issue(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b, input logic [7:0] ctl);
        int guard = 0;
        bundle_in = {fn, ctl};
        operand_a_in = a;
        operand_b_in = b;
        reg_read2_in = $urandom;
        reg_write_dest_in = 5'($urandom);
        while (m_stall() && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            n_checks++; n_fail++;
            $display("FAIL issue_timeout: stall still high after %0d cycles", guard);
        end
        @(negedge clk);
    endtask

    task automatic wait_unstall(output int n);
        n = 0;
        while (m_stall() && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            n_checks++; n_fail++;
            $display("FAIL unstall_timeout: stall still high after %0d cycles", n);
        end
    endtask

    task automatic mdu_pair(input string tag, input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] hi_exp, input logic [31:0] lo_exp);
        int n;
        issue(fn, a, b, 8'h00);
        issue(FN_MFHI, 32'h0, 32'h0, 8'h11);
        wait_unstall(n);
        check({tag, "_hi"}, alu_result_out, hi_exp);
        issue(FN_MFLO, 32'h0, 32'h0, 8'h22);
        check({tag, "_lo"}, alu_result_out, lo_exp);
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 50)) - 32'd25;
            default: return $urandom;
        endcase
    endfunction

    logic [5:0] alu_fns [14] = '{6'h00, 6'h02, 6'h03, 6'h20, 6'h21, 6'h22, 6'h23,
                                 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h3F};
    logic [5:0] mdu_fns [4]  = '{6'h18, 6'h19, 6'h1A, 6'h1B};
    logic [5:0] mov_fns [4]  = '{6'h10, 6'h11, 6'h12, 6'h13};

    initial begin
        int n;
        int r;
        logic [5:0] fn;

        repeat (2) @(posedge clk);
        #1;
        check("rst_bundle", 32'(bundle_out), 32'h0);
        check("rst_result", alu_result_out, 32'h0);
        check("rst_store", store_data_out, 32'h0);
        check("rst_dest", 32'(reg_write_dest_out), 32'h0);
        check("rst_stall", 32'(stall_out), 32'h0);
        check("rst_busy", 32'(mdu_busy_out), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        run_cmp = 1'b1;

        // MULT -2 * 3 followed by back-to-back MFHI/MFLO
        issue(FN_MULT, 32'hFFFF_FFFE, 32'd3, 8'h00);
        issue(FN_MFHI, 32'h0, 32'h0, 8'h3C);
        wait_unstall(n);
        check("mult_stall_cycles", 32'(n), 32'd33);
        check("mult_hi", alu_result_out, 32'hFFFF_FFFF);
        check("mult_hi_bundle", 32'(bundle_out), 32'h3C);
        issue(FN_MFLO, 32'h0, 32'h0, 8'h3D);
        check("mult_lo", alu_result_out, 32'hFFFF_FFFA);

        mdu_pair("multu", FN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        mdu_pair("div", FN_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        mdu_pair("divu0", FN_DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF);
        mdu_pair("divovf", FN_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);

        // ALU op flowing while the MDU iterates
        issue(FN_MULT, 32'd9, 32'd9, 8'h00);
        issue(FN_ADD, 32'd5, 32'd7, 8'hA5);
        check("add_run_result", alu_result_out, 32'd12);
        check("add_run_stall", 32'(stall_out), 32'h0);
        check("add_run_bundle", 32'(bundle_out), 32'hA5);
        check("add_run_busy", 32'(mdu_busy_out), 32'h1);

        // MTLO right behind a DIVU overrides the quotient
        issue(FN_DIVU, 32'd100, 32'd7, 8'h00);
        issue(FN_MTLO, 32'h1234, 32'h0, 8'h00);
        wait_unstall(n);
        issue(FN_MFLO, 32'h0, 32'h0, 8'h01);
        check("mtlo_lo", alu_result_out, 32'h1234);
        issue(FN_MFHI, 32'h0, 32'h0, 8'h02);
        check("mtlo_hi", alu_result_out, 32'd2);

        // Reset five cycles into a MULT
        issue(FN_MULT, 32'h1234_5678, 32'h9ABC_DEF0, 8'h00);
        repeat (5) issue(FN_ADDU, $urandom, $urandom, 8'h5A);
        #2 reset = 1'b1;
        #1;
        check("amid_bundle", 32'(bundle_out), 32'h0);
        check("amid_result", alu_result_out, 32'h0);
        check("amid_store", store_data_out, 32'h0);
        check("amid_dest", 32'(reg_write_dest_out), 32'h0);
        check("amid_stall", 32'(stall_out), 32'h0);
        check("amid_busy", 32'(mdu_busy_out), 32'h0);
        bundle_in = '0; operand_a_in = '0; operand_b_in = '0;
        @(negedge clk);
        reset = 1'b0;
        issue(FN_MFHI, 32'h0, 32'h0, 8'h07);
        check("amid_hi", alu_result_out, 32'h0);
        issue(FN_MFLO, 32'h0, 32'h0, 8'h08);
        check("amid_lo", alu_result_out, 32'h0);

        // Random instruction stream
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 10)      fn = mdu_fns[$urandom_range(0, 3)];
            else if (r < 35) fn = mov_fns[$urandom_range(0, 3)];
            else             fn = alu_fns[$urandom_range(0, 13)];
            issue(fn, pick_val(), pick_val(), 8'($urandom));
        end
        issue(FN_MFHI, 32'h0, 32'h0, 8'h00);
        wait_unstall(n);
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
